// File: rtl/vx_tex_agent_if.sv
// Handshake bundle for vx_tex_agent: execute-side requests, texture-unit requests and
// responses, and the commit stream. slave = the agent, master = its environment.
`ifndef VX_TEX_LOD_BITS
`define VX_TEX_LOD_BITS 4
`endif
`ifndef VX_TEX_STAGE_BITS
`define VX_TEX_STAGE_BITS 2
`endif

interface vx_tex_agent_if #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned META_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 3
);
    logic                                     exe_req_valid;
    logic                                     exe_req_ready;
    logic [NUM_LANES-1:0]                     exe_req_mask;
    logic [1:0][NUM_LANES-1:0][31:0]          exe_req_coords;
    logic [NUM_LANES-1:0][`VX_TEX_LOD_BITS-1:0] exe_req_lod;
    logic [`VX_TEX_STAGE_BITS-1:0]            exe_req_stage;
    logic [META_WIDTH-1:0]                    exe_req_meta;

    logic                                     tex_req_valid;
    logic                                     tex_req_ready;
    logic [NUM_LANES-1:0]                     tex_req_mask;
    logic [1:0][NUM_LANES-1:0][31:0]          tex_req_coords;
    logic [NUM_LANES-1:0][`VX_TEX_LOD_BITS-1:0] tex_req_lod;
    logic [`VX_TEX_STAGE_BITS-1:0]            tex_req_stage;
    logic [TAG_WIDTH-1:0]                     tex_req_tag;

    logic                                     tex_rsp_valid;
    logic                                     tex_rsp_ready;
    logic [NUM_LANES-1:0][31:0]               tex_rsp_texels;
    logic [TAG_WIDTH-1:0]                     tex_rsp_tag;

    logic                                     cmt_valid;
    logic                                     cmt_ready;
    logic [NUM_LANES-1:0]                     cmt_mask;
    logic [NUM_LANES-1:0][31:0]               cmt_data;
    logic [META_WIDTH-1:0]                    cmt_meta;

    modport slave (
        input  exe_req_valid, exe_req_mask, exe_req_coords, exe_req_lod, exe_req_stage,
        input  exe_req_meta, tex_req_ready, tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        input  cmt_ready,
        output exe_req_ready, tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod,
        output tex_req_stage, tex_req_tag, tex_rsp_ready, cmt_valid, cmt_mask, cmt_data,
        output cmt_meta
    );

    modport master (
        output exe_req_valid, exe_req_mask, exe_req_coords, exe_req_lod, exe_req_stage,
        output exe_req_meta, tex_req_ready, tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        output cmt_ready,
        input  exe_req_ready, tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod,
        input  tex_req_stage, tex_req_tag, tex_rsp_ready, cmt_valid, cmt_mask, cmt_data,
        input  cmt_meta
    );
endinterface

// File: rtl/vx_tex_agent.sv
// Texture agent: tags requests with a pending-table slot and turns out-of-order texel
// responses into masked commits. Optional counters under TEX_AGENT_PERF_EN.
`ifndef VX_TEX_LOD_BITS
`define VX_TEX_LOD_BITS 4
`endif
`ifndef VX_TEX_STAGE_BITS
`define VX_TEX_STAGE_BITS 2
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_tex_agent #(
    parameter int unsigned  NUM_LANES    = 4,
    parameter int unsigned  META_WIDTH   = 32,
    parameter int unsigned  PENDING_SIZE = 8,
    localparam int unsigned TAG_WIDTH    = $clog2(PENDING_SIZE)
) (
    input logic           clk,
    input logic           reset,
`ifdef TEX_AGENT_PERF_EN
    output logic [`PERF_CTR_BITS-1:0] perf_stall_cycles,
    output logic [TAG_WIDTH:0]        perf_pending,
`endif
    vx_tex_agent_if.slave bus
);
    localparam int unsigned LOD_BITS   = `VX_TEX_LOD_BITS;
    localparam int unsigned STAGE_BITS = `VX_TEX_STAGE_BITS;

    logic [PENDING_SIZE-1:0] r_valid;
    logic [PENDING_SIZE-1:0] w_valid_nxt;
    logic [NUM_LANES-1:0]    r_mask [PENDING_SIZE];
    logic [META_WIDTH-1:0]   r_meta [PENDING_SIZE];
    logic [TAG_WIDTH-1:0]    w_alloc_idx;
    logic                    w_full;
    logic                    w_req_fire;
    logic                    w_rsp_fire;

    logic                               r_treq_valid;
    logic [NUM_LANES-1:0]               r_treq_mask;
    logic [1:0][NUM_LANES-1:0][31:0]    r_treq_coords;
    logic [NUM_LANES-1:0][LOD_BITS-1:0] r_treq_lod;
    logic [STAGE_BITS-1:0]              r_treq_stage;
    logic [TAG_WIDTH-1:0]               r_treq_tag;

    logic                               r_cmt_valid;
    logic [NUM_LANES-1:0]               r_cmt_mask;
    logic [NUM_LANES-1:0][31:0]         r_cmt_data;
    logic [META_WIDTH-1:0]              r_cmt_meta;
    logic [NUM_LANES-1:0][31:0]         w_cmt_data;

    // Lowest-index free slot; full is judged on registered state only, so a same-cycle
    // free cannot raise exe_req_ready combinationally.
    always_comb begin
        w_alloc_idx = '0;
        w_full      = 1'b1;
        for (int i = int'(PENDING_SIZE) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx = TAG_WIDTH'(i);
                w_full      = 1'b0;
            end
        end
    end

    assign bus.exe_req_ready = reset && !w_full && (!r_treq_valid || bus.tex_req_ready);
    assign bus.tex_rsp_ready = reset && (!r_cmt_valid || bus.cmt_ready);
    assign w_req_fire        = bus.exe_req_valid && bus.exe_req_ready;
    assign w_rsp_fire        = bus.tex_rsp_valid && bus.tex_rsp_ready;

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_rsp_fire) w_valid_nxt[bus.tex_rsp_tag] = 1'b0;
        if (w_req_fire) w_valid_nxt[w_alloc_idx] = 1'b1;
    end

    always_comb begin
        w_cmt_data = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (r_mask[bus.tex_rsp_tag][i]) w_cmt_data[i] = bus.tex_rsp_texels[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_valid <= '0;
        else        r_valid <= w_valid_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_mask[w_alloc_idx] <= bus.exe_req_mask;
            r_meta[w_alloc_idx] <= bus.exe_req_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_treq_valid  <= 1'b0;
            r_treq_mask   <= '0;
            r_treq_coords <= '0;
            r_treq_lod    <= '0;
            r_treq_stage  <= '0;
            r_treq_tag    <= '0;
        end else if (w_req_fire) begin
            r_treq_valid  <= 1'b1;
            r_treq_mask   <= bus.exe_req_mask;
            r_treq_coords <= bus.exe_req_coords;
            r_treq_lod    <= bus.exe_req_lod;
            r_treq_stage  <= bus.exe_req_stage;
            r_treq_tag    <= w_alloc_idx;
        end else if (bus.tex_req_ready) begin
            r_treq_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmt_valid <= 1'b0;
            r_cmt_mask  <= '0;
            r_cmt_data  <= '0;
            r_cmt_meta  <= '0;
        end else if (w_rsp_fire) begin
            r_cmt_valid <= 1'b1;
            r_cmt_mask  <= r_mask[bus.tex_rsp_tag];
            r_cmt_data  <= w_cmt_data;
            r_cmt_meta  <= r_meta[bus.tex_rsp_tag];
        end else if (bus.cmt_ready) begin
            r_cmt_valid <= 1'b0;
        end
    end

    assign bus.tex_req_valid  = r_treq_valid;
    assign bus.tex_req_mask   = r_treq_mask;
    assign bus.tex_req_coords = r_treq_coords;
    assign bus.tex_req_lod    = r_treq_lod;
    assign bus.tex_req_stage  = r_treq_stage;
    assign bus.tex_req_tag    = r_treq_tag;
    assign bus.cmt_valid      = r_cmt_valid;
    assign bus.cmt_mask       = r_cmt_mask;
    assign bus.cmt_data       = r_cmt_data;
    assign bus.cmt_meta       = r_cmt_meta;

    a_rsp_tag_live: assert property (@(posedge clk) disable iff (!reset)
        w_rsp_fire |-> r_valid[bus.tex_rsp_tag]);

`ifdef TEX_AGENT_PERF_EN
    logic [`PERF_CTR_BITS-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!reset)                                         r_stall_cycles <= '0;
        else if (bus.exe_req_valid && !bus.exe_req_ready)   r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign perf_stall_cycles = r_stall_cycles;
    assign perf_pending      = (TAG_WIDTH+1)'($countones(r_valid));
`endif
endmodule

// File: tb/tb_vx_tex_agent.sv
// Randomized scoreboard bench for vx_tex_agent: a slot-level model predicts tags, commits
// and ready levels; directed sequences cover reset, fill, out-of-order and backpressure.
`ifndef VX_TEX_LOD_BITS
`define VX_TEX_LOD_BITS 4
`endif
`ifndef VX_TEX_STAGE_BITS
`define VX_TEX_STAGE_BITS 2
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_tex_agent;
    localparam int NL = 4;
    localparam int MW = 32;
    localparam int PS = 8;
    localparam int TW = 3;
    localparam int LB = `VX_TEX_LOD_BITS;
    localparam int SB = `VX_TEX_STAGE_BITS;

    typedef logic [NL-1:0][31:0] texels_t;
    typedef struct packed {
        logic [TW-1:0]              tag;
        logic [NL-1:0]              mask;
        logic [1:0][NL-1:0][31:0]   coords;
        logic [NL-1:0][LB-1:0]      lod;
        logic [SB-1:0]              stage;
    } req_t;
    typedef struct packed {
        logic [NL-1:0]  mask;
        texels_t        data;
        logic [MW-1:0]  meta;
    } cmt_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_tex_agent_if #(.NUM_LANES(NL), .META_WIDTH(MW), .TAG_WIDTH(TW)) bus ();

`ifdef TEX_AGENT_PERF_EN
    logic [`PERF_CTR_BITS-1:0] perf_stall_cycles;
    logic [TW:0]               perf_pending;
`endif

    vx_tex_agent #(.NUM_LANES(NL), .META_WIDTH(MW), .PENDING_SIZE(PS)) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef TEX_AGENT_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_pending      (perf_pending),
`endif
        .bus               (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: which slots are occupied and what they hold.
    bit            m_valid [PS];
    logic [NL-1:0] m_mask  [PS];
    logic [MW-1:0] m_meta  [PS];
    req_t exp_req_q[$];
    cmt_t exp_cmt_q[$];
    int   outst_q[$];
    bit   exe_fired;
    bit   rsp_fired;
    bit   issue_en;
    req_t ra;
    cmt_t ca;
    req_t rq;
    cmt_t cq;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < PS; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < PS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic texels_t rand_texels();
        texels_t t;
        for (int l = 0; l < NL; l++) t[l] = $urandom();
        return t;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output checker: compares DUT outputs against the head of each expectation queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("exe_req_ready", bus.exe_req_ready,
                (m_count() < PS) && (exp_req_q.size() == 0 || bus.tex_req_ready));
            chk("tex_req_valid", bus.tex_req_valid, exp_req_q.size() != 0);
            if (bus.tex_req_valid && exp_req_q.size() != 0) begin
                ra.tag    = bus.tex_req_tag;
                ra.mask   = bus.tex_req_mask;
                ra.coords = bus.tex_req_coords;
                ra.lod    = bus.tex_req_lod;
                ra.stage  = bus.tex_req_stage;
                chk("tex_req_fields", ra, exp_req_q[0]);
                if (bus.tex_req_ready) void'(exp_req_q.pop_front());
            end
            chk("tex_rsp_ready", bus.tex_rsp_ready, exp_cmt_q.size() == 0 || bus.cmt_ready);
            chk("cmt_valid", bus.cmt_valid, exp_cmt_q.size() != 0);
            if (bus.cmt_valid && exp_cmt_q.size() != 0) begin
                ca.mask = bus.cmt_mask;
                ca.data = bus.cmt_data;
                ca.meta = bus.cmt_meta;
                chk("cmt_fields", ca, exp_cmt_q[0]);
                if (bus.cmt_ready) void'(exp_cmt_q.pop_front());
            end
        end
    end

    // Input monitor: turns accepted handshakes into model updates and expectations.
    always @(negedge clk) begin
        int t;
        #1;
        exe_fired = 1'b0;
        rsp_fired = 1'b0;
        if (!reset) begin
            for (int i = 0; i < PS; i++) m_valid[i] = 1'b0;
            exp_req_q.delete();
            exp_cmt_q.delete();
            outst_q.delete();
        end else begin
            if (bus.tex_req_valid && bus.tex_req_ready) outst_q.push_back(int'(bus.tex_req_tag));
            if (bus.exe_req_valid && bus.exe_req_ready) begin
                exe_fired = 1'b1;
                t = lowest_free();
                if (t < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL alloc_when_full: got accept expected stall at %0t", $time);
                end else begin
                    m_valid[t] = 1'b1;
                    m_mask[t]  = bus.exe_req_mask;
                    m_meta[t]  = bus.exe_req_meta;
                    rq.tag     = TW'(t);
                    rq.mask    = bus.exe_req_mask;
                    rq.coords  = bus.exe_req_coords;
                    rq.lod     = bus.exe_req_lod;
                    rq.stage   = bus.exe_req_stage;
                    exp_req_q.push_back(rq);
                end
            end
            if (bus.tex_rsp_valid && bus.tex_rsp_ready) begin
                rsp_fired = 1'b1;
                t = int'(bus.tex_rsp_tag);
                cq.mask = m_mask[t];
                cq.meta = m_meta[t];
                for (int l = 0; l < NL; l++) cq.data[l] = m_mask[t][l] ? bus.tex_rsp_texels[l] : 32'd0;
                exp_cmt_q.push_back(cq);
                m_valid[t] = 1'b0;
                for (int i = 0; i < outst_q.size(); i++) begin
                    if (outst_q[i] == t) begin
                        outst_q.delete(i);
                        break;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_exe_fields();
        for (int l = 0; l < NL; l++) begin
            bus.exe_req_coords[0][l] = $urandom();
            bus.exe_req_coords[1][l] = $urandom();
            bus.exe_req_lod[l]       = LB'($urandom());
        end
        bus.exe_req_stage = SB'($urandom());
    endtask

    task automatic send_req(input logic [NL-1:0] mask, input logic [MW-1:0] meta);
        bus.exe_req_valid = 1'b1;
        bus.exe_req_mask  = mask;
        bus.exe_req_meta  = meta;
        rand_exe_fields();
        #1;
        for (int n = 0; n < 50 && !bus.exe_req_ready; n++) tick();
        if (!bus.exe_req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_accept: got ready=0 expected ready=1 within 50 cycles");
        end
        tick();
        bus.exe_req_valid = 1'b0;
    endtask

    task automatic send_rsp(input int tag, input texels_t tx);
        bus.tex_rsp_valid  = 1'b1;
        bus.tex_rsp_tag    = TW'(tag);
        bus.tex_rsp_texels = tx;
        #1;
        for (int n = 0; n < 50 && !bus.tex_rsp_ready; n++) tick();
        if (!bus.tex_rsp_ready) begin
            checks++;
            failures++;
            $display("FAIL rsp_accept: got ready=0 expected ready=1 within 50 cycles");
        end
        tick();
        bus.tex_rsp_valid = 1'b0;
    endtask

    task automatic drive_random();
        if (!bus.exe_req_valid || exe_fired) begin
            bus.exe_req_valid = issue_en && ($urandom_range(0, 3) != 0);
            bus.exe_req_mask  = NL'($urandom());
            bus.exe_req_meta  = $urandom();
            rand_exe_fields();
        end
        if (!bus.tex_rsp_valid || rsp_fired) begin
            if (outst_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                bus.tex_rsp_valid  = 1'b1;
                bus.tex_rsp_tag    = TW'(outst_q[$urandom_range(0, outst_q.size() - 1)]);
                bus.tex_rsp_texels = rand_texels();
            end else begin
                bus.tex_rsp_valid = 1'b0;
            end
        end
        bus.tex_req_ready = !issue_en || ($urandom_range(0, 3) != 0);
        bus.cmt_ready     = !issue_en || ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int guard;
        issue_en           = 1'b0;
        bus.exe_req_valid  = 1'b0;
        bus.exe_req_mask   = '0;
        bus.exe_req_coords = '0;
        bus.exe_req_lod    = '0;
        bus.exe_req_stage  = '0;
        bus.exe_req_meta   = '0;
        bus.tex_req_ready  = 1'b1;
        bus.tex_rsp_valid  = 1'b0;
        bus.tex_rsp_texels = '0;
        bus.tex_rsp_tag    = '0;
        bus.cmt_ready      = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_exe_req_ready", bus.exe_req_ready, 1'b0);
        chk("rst_tex_rsp_ready", bus.tex_rsp_ready, 1'b0);
        chk("rst_tex_req_valid", bus.tex_req_valid, 1'b0);
        chk("rst_cmt_valid", bus.cmt_valid, 1'b0);
        chk("rst_tex_req_tag", bus.tex_req_tag, 0);
        chk("rst_cmt_data", bus.cmt_data, 0);
        chk("rst_cmt_meta", bus.cmt_meta, 0);
        reset = 1'b1;

        // Single request, partial mask
        send_req(4'b1011, 32'h1234);
        chk("single_tag", bus.tex_req_tag, 0);
        chk("single_tex_req_valid", bus.tex_req_valid, 1'b1);
        tick();
        send_rsp(0, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("single_cmt_valid", bus.cmt_valid, 1'b1);
        chk("single_cmt_data", bus.cmt_data, {32'd4, 32'd0, 32'd2, 32'd1});
        chk("single_cmt_meta", bus.cmt_meta, 32'h1234);
        chk("single_cmt_mask", bus.cmt_mask, 4'b1011);
        tick();

        // Fill the table, then free one slot and reuse it
        for (int i = 0; i < PS; i++) send_req(NL'($urandom()), 32'h100 + i);
        bus.exe_req_valid = 1'b1;
        bus.exe_req_mask  = 4'b0110;
        bus.exe_req_meta  = 32'h108;
        #1;
        chk("full_ready_low", bus.exe_req_ready, 1'b0);
        repeat (3) tick();
        chk("full_still_low", bus.exe_req_ready, 1'b0);
`ifdef TEX_AGENT_PERF_EN
        chk("perf_stall_cycles", perf_stall_cycles, 3);
        chk("perf_pending", perf_pending, 8);
`endif
        send_rsp(5, rand_texels());
        bus.exe_req_valid = 1'b1;
        #1;
        chk("free_ready_rise", bus.exe_req_ready, 1'b1);
        tick();
        bus.exe_req_valid = 1'b0;
        chk("reuse_tag", bus.tex_req_tag, 5);

        // Out-of-order responses
        send_rsp(3, rand_texels());
        send_rsp(0, rand_texels());
        send_rsp(7, rand_texels());
        tick();

        // Commit backpressure
        bus.cmt_ready = 1'b0;
        send_rsp(1, rand_texels());
        bus.tex_rsp_valid  = 1'b1;
        bus.tex_rsp_tag    = 3'd2;
        bus.tex_rsp_texels = rand_texels();
        repeat (10) tick();
        chk("bp_rsp_ready", bus.tex_rsp_ready, 1'b0);
        chk("bp_cmt_valid", bus.cmt_valid, 1'b1);
        chk("bp_cmt_meta", bus.cmt_meta, 32'h101);
        bus.cmt_ready = 1'b1;
        send_rsp(2, rand_texels());
        send_rsp(4, rand_texels());
        send_rsp(5, rand_texels());
        send_rsp(6, rand_texels());
        repeat (2) tick();

        // Reset with pending entries
        for (int i = 0; i < 4; i++) send_req(NL'($urandom()), $urandom());
        reset = 1'b0;
        tick();
        chk("mid_rst_tex_req_valid", bus.tex_req_valid, 1'b0);
        chk("mid_rst_cmt_valid", bus.cmt_valid, 1'b0);
        chk("mid_rst_exe_ready", bus.exe_req_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("post_rst_exe_ready", bus.exe_req_ready, 1'b1);
        send_req(4'b1111, 32'hABCD);
        chk("post_rst_tag", bus.tex_req_tag, 0);

        // Random traffic
        issue_en = 1'b1;
        repeat (3000) begin
            tick();
            drive_random();
        end

        // Drain
        issue_en = 1'b0;
        guard = 0;
        while ((m_count() != 0 || bus.exe_req_valid || exp_cmt_q.size() != 0 ||
                exp_req_q.size() != 0) && guard < 1000) begin
            tick();
            drive_random();
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", m_count());
        end
        bus.tex_rsp_valid = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vx_tex_agent.md
VX_TEX_AGENT -- requirements
Module: VX_tex_agent

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per request.
REQ-002 SHALL have parameter META_WIDTH, default 32: opaque writeback metadata width (wid/PC/rd/uuid).
REQ-003 SHALL have parameter PENDING_SIZE, default 8, power of two >=2: outstanding requests; TAG_WIDTH = CLOG2(PENDING_SIZE).
REQ-004 SHALL have ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset.
exe_req_valid / exe_req_ready  in / out  1  execute-side request handshake.
exe_req_mask  in  NUM_LANES  active lanes.
exe_req_coords  in  2xNUM_LANESx32  u,v per lane.
exe_req_lod  in  NUM_LANESx`VX_TEX_LOD_BITS  mip level per lane.
exe_req_stage  in  `VX_TEX_STAGE_BITS  sampler stage.
exe_req_meta  in  META_WIDTH  writeback metadata.
tex_req_valid / tex_req_ready  out / in  1  texture-unit request handshake.
tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage  out  as exe_req_*  forwarded fields.
tex_req_tag  out  TAG_WIDTH  pending-table index.
tex_rsp_valid / tex_rsp_ready  in / out  1  texture-unit response handshake.
tex_rsp_texels  in  NUM_LANESx32  sampled texels.
tex_rsp_tag  in  TAG_WIDTH  returned tag.
cmt_valid / cmt_ready  out / in  1  commit handshake.
cmt_mask  out  NUM_LANES; cmt_data  out  NUM_LANESx32; cmt_meta  out  META_WIDTH.

Function
REQ-005 SHALL keep a pending table of PENDING_SIZE entries, each {valid, mask, meta}.
REQ-006 SHALL assert exe_req_ready = table not full AND request output register empty-or-draining.
REQ-007 On exe_req fire, SHALL allocate lowest-index free entry, store mask/meta, and present request on tex_req_* next cycle (1-cycle registered latency, tag = allocated index).
REQ-008 tex_req_* SHALL hold stable while tex_req_valid high and tex_req_ready low.
REQ-009 Responses MAY arrive in any order; on tex_rsp fire SHALL read entry[tex_rsp_tag] and present cmt_* next cycle (1-cycle registered latency).
REQ-010 cmt_data lane i SHALL equal tex_rsp_texels[i] when stored mask[i]=1, else 0; cmt_mask/cmt_meta SHALL equal stored values.
REQ-011 tex_rsp_ready SHALL equal commit output register empty-or-draining (cmt_ready or !cmt_valid).
REQ-012 Entry SHALL be freed on tex_rsp fire; freed entry SHALL be allocatable the following cycle.
REQ-013 Simultaneous allocate and free in one cycle SHALL both take effect; when full, a free SHALL not make exe_req_ready rise in the same cycle.
REQ-014 Response to a non-valid entry SHALL trigger simulation assertion; RTL behaviour then undefined.
REQ-015 Throughput SHALL be one request and one response per cycle with no bubbles when not back-pressured.

Reset
REQ-016 While reset=0 at clk edge: all entries invalid, tex_req_valid=0, cmt_valid=0, exe_req_ready=0, tex_rsp_ready=0; data outputs 0.
REQ-017 Reset mid-operation SHALL discard all pending entries and in-flight registers; first cycle after release exe_req_ready=1.

Configuration
REQ-018 Macro TEX_AGENT_PERF_EN: when defined, SHALL add outputs perf_stall_cycles (`PERF_CTR_BITS, +1 per cycle exe_req_valid & !exe_req_ready) and perf_pending (TAG_WIDTH+1, current valid-entry count), both 0 on reset; when undefined, ports and counters SHALL be absent with identical functional behaviour.

Verification
REQ-019 Single request mask=4'b1011, meta=0x1234, tex_rsp one cycle after tex_req fire with texels 1,2,3,4 -> tex_req_tag=0; cmt_data={1,2,0,4}, cmt_meta=0x1234, cmt_valid 1 cycle after rsp fire.
REQ-020 Issue 8 requests, tex_req_ready=1, no responses -> tags 0..7, exe_req_ready=0 on 9th; one response tag 5 -> ready rises next cycle, 9th request gets tag 5.
REQ-021 Responses returned in order 3,0,7 -> cmt_meta order matches tags 3,0,7 with correct per-entry masks.
REQ-022 cmt_ready=0 for 10 cycles with rsp pending -> tex_rsp_ready=0 after first commit held, cmt_* stable; release -> drains one per cycle.
REQ-023 Assert reset=0 with 4 pending entries -> next cycle all outputs valid=0; after release, next request gets tag 0.
REQ-024 With TEX_AGENT_PERF_EN, hold exe_req_valid during 3 full cycles -> perf_stall_cycles=3, perf_pending=8.
